// File: rtl/bg_fetch_pkg.sv
// Shared geometry, types and scroll-wrap helper for the Red Dead background fetcher.
package bg_fetch_pkg;

  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int ADDR_W   = 17;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [3:0] BLANK_INDEX = 4'h3;

  typedef logic [3:0]        pal_idx_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [8:0]        scroll_t;

  // Both operands are below IMG_W, so a single conditional subtract wraps.
  function automatic scroll_t wrap_add(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] sum;
    logic [9:0] res;
    sum = a + b;
    res = (sum >= 10'(IMG_W)) ? (sum - 10'(IMG_W)) : sum;
    return res[8:0];
  endfunction

endpackage

// File: rtl/bg_scroll_reg.sv
// Per-frame horizontal scroll accumulator, advanced once on each vs_in falling edge.
// With BG_FETCH_VFLIP_EN defined it also latches the vertical-flip request per frame.
module bg_scroll_reg
  import bg_fetch_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs_in,
  input  logic       scroll_en,
  input  logic [3:0] scroll_step,
`ifdef BG_FETCH_VFLIP_EN
  input  logic       vflip,
  output logic       vflip_out,
`endif
  output logic [8:0] scroll_x
);

  scroll_t scroll_x_q, scroll_x_d;
  logic    vs_prev_q, vs_prev_d;
  logic    frame_start;

  // Edge detect makes a long vsync pulse count as a single frame.
  always_comb begin
    frame_start = vs_prev_q & ~vs_in;
    vs_prev_d   = vs_in;
    scroll_x_d  = scroll_x_q;
    if (frame_start && scroll_en) begin
      scroll_x_d = wrap_add({1'b0, scroll_x_q}, {6'd0, scroll_step});
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scroll_x_q <= '0;
      vs_prev_q  <= 1'b1;
    end else begin
      scroll_x_q <= scroll_x_d;
      vs_prev_q  <= vs_prev_d;
    end
  end

`ifdef BG_FETCH_VFLIP_EN
  logic vflip_q, vflip_d;

  always_comb begin
    vflip_d = vflip_q;
    if (frame_start) begin
      vflip_d = vflip;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vflip_q <= 1'b0;
    end else begin
      vflip_q <= vflip_d;
    end
  end

  assign vflip_out = vflip_q;
`endif

  assign scroll_x = scroll_x_q;

endmodule

// File: rtl/bg_red_dead_fetch.sv
// Background pixel fetcher: scan coords -> scrolled, 2x-upscaled ROM address -> palette index.
// Three-edge pipeline (address reg, ROM reg, index reg); optional BG_FETCH_VFLIP_EN adds vflip.
module bg_red_dead_fetch
  import bg_fetch_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank_in,
  input  logic              vs_in,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_step,
`ifdef BG_FETCH_VFLIP_EN
  input  logic              vflip,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        index_out,
  output logic              blank_out
);

  logic [8:0] scroll_x;
  logic       vflip_act;

  bg_scroll_reg u_scroll (
    .Clk         (Clk),
    .Reset       (Reset),
    .vs_in       (vs_in),
    .scroll_en   (scroll_en),
    .scroll_step (scroll_step),
`ifdef BG_FETCH_VFLIP_EN
    .vflip       (vflip),
    .vflip_out   (vflip_act),
`endif
    .scroll_x    (scroll_x)
  );

`ifndef BG_FETCH_VFLIP_EN
  assign vflip_act = 1'b0;
`endif

  rom_addr_t  rom_addr_q, rom_addr_d;
  logic       vld1_q, vld1_d, blk1_q, blk1_d;
  logic       vld2_q, vld2_d, blk2_q, blk2_d;
  pal_idx_t   index_q, index_d;
  logic       blank_q, blank_d;

  logic       pix_vld;
  logic [8:0] sx, sy;
  logic [9:0] tx_sum, tx;
  rom_addr_t  addr_calc;

  always_comb begin
    pix_vld = blank_in && (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
    sx      = DrawX[9:1];
    sy      = DrawY[9:1];
    if (vflip_act) begin
      sy = 9'(IMG_H - 1) - DrawY[9:1];
    end
    tx_sum    = {1'b0, sx} + {1'b0, scroll_x};
    tx        = (tx_sum >= 10'(IMG_W)) ? (tx_sum - 10'(IMG_W)) : tx_sum;
    // sy*320 as shift-add: 256 + 64.
    addr_calc = ({8'd0, sy} << 8) + ({8'd0, sy} << 6) + {7'd0, tx};

    // Hold the address on invalid pixels so the ROM bus stays quiet.
    rom_addr_d = pix_vld ? addr_calc : rom_addr_q;
    vld1_d     = pix_vld;
    blk1_d     = blank_in;
    vld2_d     = vld1_q;
    blk2_d     = blk1_q;
    index_d    = vld2_q ? rom_data : BLANK_INDEX;
    blank_d    = blk2_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q <= '0;
      vld1_q     <= 1'b0;
      blk1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      blk2_q     <= 1'b0;
      index_q    <= BLANK_INDEX;
      blank_q    <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      vld1_q     <= vld1_d;
      blk1_q     <= blk1_d;
      vld2_q     <= vld2_d;
      blk2_q     <= blk2_d;
      index_q    <= index_d;
      blank_q    <= blank_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign index_out = index_q;
  assign blank_out = blank_q;

endmodule

// File: tb/tb_bg_red_dead_fetch.sv
// Scoreboard bench for bg_red_dead_fetch (default build, vertical flip disabled).
module tb_bg_red_dead_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank_in = 1'b0;
  logic        vs_in = 1'b1;
  logic        scroll_en = 1'b0;
  logic [3:0]  scroll_step = '0;
  logic [16:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic [3:0]  index_out;
  logic        blank_out;

  bg_red_dead_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank_in    (blank_in),
    .vs_in       (vs_in),
    .scroll_en   (scroll_en),
    .scroll_step (scroll_step),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .index_out   (index_out),
    .blank_out   (blank_out)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_fn(input logic [16:0] a);
    return a[3:0] ^ a[9:6] ^ 4'hD;
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  idx;
    logic        blk;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  int   m_scroll = 0;
  int   m_addr   = 0;
  logic m_vsprev = 1'b1;

  task automatic model_reset();
    sb.delete();
    m_scroll = 0;
    m_addr   = 0;
    m_vsprev = 1'b1;
  endtask

  // One pixel per clock: drive, predict, advance one edge, then score.
  task automatic step(input string nm, input int x, input int y, input logic b,
                      input logic vs, input logic en, input int stp);
    exp_t e;
    int   tx;
    logic v;
    DrawX = 10'(x); DrawY = 10'(y); blank_in = b;
    vs_in = vs; scroll_en = en; scroll_step = 4'(stp);
    v = b && (x < 640) && (y < 480);
    if (v) begin
      tx = (x / 2) + m_scroll;
      if (tx >= 320) tx = tx - 320;
      m_addr = (y / 2) * 320 + tx;
    end
    e.due = cyc + 3;
    e.idx = v ? rom_fn(17'(m_addr)) : 4'h3;
    e.blk = b;
    sb.push_back(e);
    if (m_vsprev && !vs && en) begin
      m_scroll = m_scroll + stp;
      if (m_scroll >= 320) m_scroll = m_scroll - 320;
    end
    m_vsprev = vs;
    @(posedge Clk); #1;
    n_cmp++;
    if (rom_addr !== 17'(m_addr)) begin
      n_bad++;
      $display("FAIL %s rom_addr got %0d want %0d", nm, rom_addr, m_addr);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (index_out !== e.idx || blank_out !== e.blk) begin
        n_bad++;
        $display("FAIL %s index/blank got %h/%b want %h/%b", nm, index_out, blank_out, e.idx, e.blk);
      end
    end
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if (rom_addr !== 17'd0 || index_out !== 4'h3 || blank_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async got addr=%0d idx=%h blk=%b want 0/3/0", rom_addr, index_out, blank_out);
    end
    @(posedge Clk); #2;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) step("pre_reset", 90 + i, 20, 1'b1, 1'b1, 1'b0, 0);
    DrawX = 10'd100;
    do_reset();
    step("rst_e1", 0, 0, 1'b1, 1'b1, 1'b0, 0);
    step("rst_e2", 2, 0, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (index_out !== 4'h3) begin
      n_bad++;
      $display("FAIL reset_early_idx got %h want 3", index_out);
    end
    step("rst_e3", 4, 0, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (index_out !== 4'hD || blank_out !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_valid got %h/%b want d/1", index_out, blank_out);
    end
  endtask

  task automatic test_origin();
    do_reset();
    step("origin", 0, 0, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (rom_addr !== 17'd0) begin
      n_bad++;
      $display("FAIL origin_addr got %0d want 0", rom_addr);
    end
    step("origin_f1", 0, 0, 1'b0, 1'b1, 1'b0, 0);
    step("origin_f2", 0, 0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_corner();
    step("corner", 639, 479, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (rom_addr !== 17'd76799) begin
      n_bad++;
      $display("FAIL corner_addr got %0d want 76799", rom_addr);
    end
    step("edge640", 640, 479, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (rom_addr !== 17'd76799) begin
      n_bad++;
      $display("FAIL hold_addr got %0d want 76799", rom_addr);
    end
    step("edge_f1", 700, 479, 1'b1, 1'b1, 1'b0, 0);
    step("edge_f2", 10, 480, 1'b1, 1'b1, 1'b0, 0);
    step("edge_f3", 12, 12, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_blank();
    step("blank", 10, 10, 1'b0, 1'b1, 1'b0, 0);
    step("blank_f1", 20, 10, 1'b1, 1'b1, 1'b0, 0);
    step("blank_f2", 22, 10, 1'b1, 1'b1, 1'b0, 0);
    step("blank_f3", 24, 10, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_scroll_wrap();
    for (int i = 0; i < 21; i++) begin
      step("scr_lo", 700, 500, 1'b0, 1'b0, 1'b1, 15);
      step("scr_hi", 700, 500, 1'b0, 1'b1, 1'b1, 15);
    end
    step("wrap_lo", 700, 500, 1'b0, 1'b0, 1'b1, 10);
    step("wrap_hi", 700, 500, 1'b0, 1'b1, 1'b0, 10);
    step("scroll_px", 20, 2, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (rom_addr !== 17'd335) begin
      n_bad++;
      $display("FAIL scroll_wrap_addr got %0d want 335", rom_addr);
    end
    step("scroll_f1", 638, 2, 1'b1, 1'b1, 1'b0, 0);
    step("scroll_f2", 0, 0, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_long_vsync();
    do_reset();
    for (int i = 0; i < 40; i++) step("vs_long", 700, 500, 1'b0, 1'b0, 1'b1, 4);
    step("vs_rise", 700, 500, 1'b0, 1'b1, 1'b1, 4);
    step("vs_px", 0, 0, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (rom_addr !== 17'd4) begin
      n_bad++;
      $display("FAIL single_update got %0d want 4", rom_addr);
    end
    for (int i = 0; i < 40; i++) step("vs_noen", 700, 500, 1'b0, 1'b0, 1'b0, 4);
    step("vs_rise2", 700, 500, 1'b0, 1'b1, 1'b0, 4);
    step("vs_px2", 0, 0, 1'b1, 1'b1, 1'b0, 0);
    n_cmp++;
    if (rom_addr !== 17'd4) begin
      n_bad++;
      $display("FAIL en_off_hold got %0d want 4", rom_addr);
    end
    step("vs_step0_lo", 700, 500, 1'b0, 1'b0, 1'b1, 0);
    step("vs_step0_hi", 700, 500, 1'b0, 1'b1, 1'b1, 0);
    step("vs_px3", 6, 4, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      step("b2b", $urandom_range(0, 799), $urandom_range(0, 524),
           1'($urandom_range(0, 3) != 0), 1'b1, 1'b0, 0);
    end
    for (int i = 0; i < 3; i++) step("b2b_drain", 800, 0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    #12 Reset = 1'b0;
    model_reset();
    test_reset();
    test_origin();
    test_corner();
    test_blank();
    test_scroll_wrap();
    test_back_to_back();
    test_long_vsync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
